instr_fetch: RTL and testbench

Instruction fetch stage for the cpu16 core. It sits directly upstream of the combinational instruction ROM: it owns the program counter, drives the ROM address, and captures each returned 16-bit word into a 2-entry prefetch queue. It presents `{pc, instr}` pairs to the decode stage over a valid/ready handshake. Decode/execute can redirect it on a jump/branch, or halt it.

---
 rtl/cpu16_pkg.sv | 14 +
 rtl/instr_fetch_if.sv | 26 ++
 rtl/fetch_queue.sv | 40 ++++
 rtl/instr_fetch.sv | 58 +++++
 tb/tb_instr_fetch.sv | 162 ++++++++++++++++
 5 files changed

// File: rtl/cpu16_pkg.sv
// cpu16_pkg: shared word/address types and fetch queue parameters for the cpu16 core.
package cpu16_pkg;

   typedef logic [15:0] word_t;
   typedef logic [15:0] addr_t;

   typedef struct packed {
      addr_t pc;
      word_t instr;
   } fetch_entry_t;

   localparam int FETCH_Q_DEPTH = 2;

endpackage

// File: rtl/instr_fetch_if.sv
// instr_fetch_if: ROM, redirect/halt control and decode handshake of the fetch stage.
interface instr_fetch_if;
   import cpu16_pkg::*;

   addr_t rom_addr;
   word_t rom_data;
   logic  redirect_valid;
   addr_t redirect_pc;
   logic  halt;
   logic  out_valid;
   logic  out_ready;
   word_t out_instr;
   addr_t out_pc;
   word_t stall_cnt;

   modport master (
      output rom_addr, out_valid, out_instr, out_pc, stall_cnt,
      input  rom_data, redirect_valid, redirect_pc, halt, out_ready
   );

   modport slave (
      input  rom_addr, out_valid, out_instr, out_pc, stall_cnt,
      output rom_data, redirect_valid, redirect_pc, halt, out_ready
   );

endinterface

// File: rtl/fetch_queue.sv
// fetch_queue: 2-entry FIFO of {pc, instr}; flush empties it and wins over push/pop.
module fetch_queue
   import cpu16_pkg::*;
(
   input  logic         clk,
   input  logic         rst_n,
   input  logic         push,
   input  logic         pop,
   input  logic         flush,
   input  fetch_entry_t din,
   output logic         full,
   output logic         empty,
   output fetch_entry_t head
);

   fetch_entry_t mem [FETCH_Q_DEPTH];
   logic         hd, tl;
   logic [1:0]   cnt;

   assign full  = cnt == 2'(FETCH_Q_DEPTH);
   assign empty = cnt == 2'd0;
   assign head  = mem[hd];

   // Storage carries no reset; validity is tracked by cnt alone.
   always_ff @(posedge clk)
      if (push && !flush) mem[tl] <= din;

   always_ff @(posedge clk) begin
      if (!rst_n || flush) begin
         hd  <= 1'b0;
         tl  <= 1'b0;
         cnt <= 2'd0;
      end else begin
         if (push) tl <= ~tl;
         if (pop) hd <= ~hd;
         cnt <= cnt + 2'(push) - 2'(pop);
      end
   end

endmodule

// File: rtl/instr_fetch.sv
// instr_fetch: cpu16 fetch stage owning the PC, feeding a 2-entry prefetch queue from a
// combinational ROM. Optional decode-starvation counter under `FETCH_STALL_CNT_EN.
module instr_fetch
   import cpu16_pkg::*;
#(
   parameter addr_t RESET_PC = 16'h0000
)(
   input logic            clk,
   input logic            rst_n,
   instr_fetch_if.master  bus
);

   addr_t        pc;
   logic         full, empty, pop, push;
   fetch_entry_t head;

   assign bus.rom_addr  = pc;
   assign bus.out_valid = !empty;
   assign bus.out_instr = head.instr;
   assign bus.out_pc    = head.pc;

   // A full queue may still accept a word when the head leaves in the same cycle.
   assign pop  = !empty && bus.out_ready;
   assign push = !bus.halt && !bus.redirect_valid && (!full || pop);

   fetch_queue u_queue (
      .clk   (clk),
      .rst_n (rst_n),
      .push  (push),
      .pop   (pop && !bus.redirect_valid),
      .flush (bus.redirect_valid),
      .din   ('{pc: pc, instr: bus.rom_data}),
      .full  (full),
      .empty (empty),
      .head  (head)
   );

   always_ff @(posedge clk) begin
      if (!rst_n) pc <= RESET_PC;
      else if (bus.redirect_valid) pc <= bus.redirect_pc;
      else if (push) pc <= pc + 16'd1;
   end

`ifdef FETCH_STALL_CNT_EN
   word_t stall_q;

   always_ff @(posedge clk) begin
      if (!rst_n) stall_q <= '0;
      else if (bus.out_ready && empty && !bus.redirect_valid && stall_q != 16'hFFFF)
         stall_q <= stall_q + 16'd1;
   end

   assign bus.stall_cnt = stall_q;
`else
   assign bus.stall_cnt = '0;
`endif

endmodule

// File: tb/tb_instr_fetch.sv
// tb_instr_fetch: directed self-checking bench for instr_fetch with a small ROM model.
module tb_instr_fetch;
   import cpu16_pkg::*;

`ifdef FETCH_STALL_CNT_EN
   localparam bit STALL_EN = 1'b1;
`else
   localparam bit STALL_EN = 1'b0;
`endif

   logic clk = 1'b0;
   logic rst_n;
   int   tests = 0;
   int   fails = 0;

   instr_fetch_if bus ();

   instr_fetch #(.RESET_PC(16'h0000)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   always #5 clk = ~clk;

   function automatic word_t rom(input addr_t a);
      case (a)
         16'h0000: rom = 16'h71FF;
         16'h0001: rom = 16'h48BA;
         16'h0002: rom = 16'h6808;
         16'h0016: rom = 16'h8800;
         16'h0017: rom = 16'h9001;
         16'hFFFF: rom = 16'h1234;
         default:  rom = {4'hF, a[11:0]};
      endcase
   endfunction

   assign bus.rom_data = rom(bus.rom_addr);

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic chk_out(input string tag, input addr_t p, input word_t i);
      chk({tag, ".valid"}, 16'(bus.out_valid), 16'd1);
      chk({tag, ".pc"}, bus.out_pc, p);
      chk({tag, ".instr"}, bus.out_instr, i);
   endtask

   initial begin
      rst_n = 1'b0;
      bus.redirect_valid = 1'b0;
      bus.redirect_pc = '0;
      bus.halt = 1'b0;
      bus.out_ready = 1'b1;
      tick();
      chk("rst.valid", 16'(bus.out_valid), 16'd0);
      chk("rst.rom_addr", bus.rom_addr, 16'h0000);
      chk("rst.stall", bus.stall_cnt, 16'h0000);

      // streaming with out_ready high
      rst_n = 1'b1;
      tick();
      chk_out("s0", 16'h0000, 16'h71FF);
      chk("s0.rom_addr", bus.rom_addr, 16'h0001);
      tick();
      chk_out("s1", 16'h0001, 16'h48BA);
      tick();
      chk_out("s2", 16'h0002, 16'h6808);

      // back-pressure fills the queue
      rst_n = 1'b0;
      bus.out_ready = 1'b0;
      tick();
      rst_n = 1'b1;
      tick();
      chk("bp1.count1", 16'(bus.out_valid), 16'd1);
      for (int k = 0; k < 4; k++) begin
         tick();
         chk_out("bp.head", 16'h0000, 16'h71FF);
         chk("bp.pc", bus.rom_addr, 16'h0002);
      end
      bus.out_ready = 1'b1;
      tick();
      chk_out("bp.rel1", 16'h0001, 16'h48BA);
      chk("bp.rel1.pc", bus.rom_addr, 16'h0003);
      tick();
      chk_out("bp.rel2", 16'h0002, 16'h6808);

      // redirect while full, popping
      bus.redirect_valid = 1'b1;
      bus.redirect_pc = 16'h0016;
      tick();
      bus.redirect_valid = 1'b0;
      chk("rd.flushed", 16'(bus.out_valid), 16'd0);
      chk("rd.rom_addr", bus.rom_addr, 16'h0016);
      tick();
      chk_out("rd.t0", 16'h0016, 16'h8800);
      tick();
      chk_out("rd.t1", 16'h0017, 16'h9001);

      // halt drains the queue and holds pc
      bus.halt = 1'b1;
      for (int k = 0; k < 4; k++) begin
         tick();
         chk("halt.valid", 16'(bus.out_valid), 16'd0);
         chk("halt.pc", bus.rom_addr, 16'h0018);
      end
      bus.halt = 1'b0;
      tick();
      chk_out("halt.resume", 16'h0018, 16'hF018);

      // redirect to the top of the address space and wrap
      bus.redirect_valid = 1'b1;
      bus.redirect_pc = 16'hFFFF;
      tick();
      bus.redirect_valid = 1'b0;
      chk("wrap.rom_addr0", bus.rom_addr, 16'hFFFF);
      tick();
      chk_out("wrap.t0", 16'hFFFF, 16'h1234);
      chk("wrap.rom_addr1", bus.rom_addr, 16'h0000);
      tick();
      chk_out("wrap.t1", 16'h0000, 16'h71FF);
      chk("wrap.rom_addr2", bus.rom_addr, 16'h0001);

      // stall counter: redirect cycle excluded, halted empty cycles counted
      rst_n = 1'b0;
      tick();
      rst_n = 1'b1;
      bus.redirect_valid = 1'b1;
      bus.redirect_pc = 16'h0016;
      tick();
      chk("st.redir", bus.stall_cnt, 16'd0);
      bus.redirect_valid = 1'b0;
      bus.halt = 1'b1;
      tick();
      chk("st.h1", bus.stall_cnt, STALL_EN ? 16'd1 : 16'd0);
      tick();
      chk("st.h2", bus.stall_cnt, STALL_EN ? 16'd2 : 16'd0);
      tick();
      chk("st.h3", bus.stall_cnt, STALL_EN ? 16'd3 : 16'd0);
      bus.halt = 1'b0;
      tick();
      chk("st.fetch", bus.stall_cnt, STALL_EN ? 16'd4 : 16'd0);
      chk_out("st.head", 16'h0016, 16'h8800);
      tick();
      chk("st.busy", bus.stall_cnt, STALL_EN ? 16'd4 : 16'd0);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
